syrk_stream_loader: RTL

Input-side deserializer for the SYRK matrix engine (C = alpha·A·Aᵀ + beta·C). It consumes the 32-bit serial word stream: alpha, beta, then A row-major (N×N), then C row-major (N×N). It latches the two scalars and converts the matrix words into addressed write strobes for the engine's A and C buffers, then signals the compute core to start. It is the receiving end of the stream the system bench drives into `Din`.

---
 rtl/syrk_stream_loader_if.sv | 29 ++
 rtl/syrk_stream_loader.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/syrk_stream_loader_if.sv
// Stream-in / buffer-write bundle for the SYRK input loader.
// The slave side is the loader; the master side feeds words and observes strobes.
interface syrk_stream_loader_if #(
  parameter int DW = 32,
  parameter int AW = 14
);
  logic [DW-1:0] Din;
  logic          din_valid;
  logic          rearm;
  logic [DW-1:0] alpha;
  logic [DW-1:0] beta;
  logic          a_we;
  logic          c_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic          overrun;

  modport master (
    output Din, din_valid, rearm,
    input  alpha, beta, a_we, c_we, wr_addr, wr_data, start, busy, overrun
  );

  modport slave (
    input  Din, din_valid, rearm,
    output alpha, beta, a_we, c_we, wr_addr, wr_data, start, busy, overrun
  );
endinterface

// File: rtl/syrk_stream_loader.sv
// Deserializes alpha, beta, A and C from the word stream into addressed buffer writes.
// Optional SYRK_LOWER_TRI_EN: store only the lower triangle of C (col <= row).
module syrk_stream_loader #(
  parameter int N  = 100,
  parameter int DW = 32,
  parameter int AW = 14
) (
  input logic                 clk,
  input logic                 rst,
  syrk_stream_loader_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_ALPHA = 3'd0;
  localparam logic [2:0] S_BETA  = 3'd1;
  localparam logic [2:0] S_A     = 3'd2;
  localparam logic [2:0] S_C     = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  logic [2:0]    state_r;
  logic [CW-1:0] col_r;
  logic [CW-1:0] row_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] alpha_r;
  logic [DW-1:0] beta_r;
  logic          a_we_r;
  logic          c_we_r;
  logic [AW-1:0] wr_addr_r;
  logic [DW-1:0] wr_data_r;
  logic          start_r;
  logic          busy_r;
  logic          overrun_r;

  logic          last_s;
  logic          c_keep_s;
  logic [CW-1:0] col_nx_s;
  logic [CW-1:0] row_nx_s;
  logic [AW-1:0] addr_nx_s;

  // Raster-order counter advance; addr tracks row*N+col by plain increment.
  always_comb begin
    last_s    = (row_r == LAST_IDX) && (col_r == LAST_IDX);
    addr_nx_s = addr_r + {{(AW-1){1'b0}}, 1'b1};
    if (col_r == LAST_IDX) begin
      col_nx_s = {CW{1'b0}};
      row_nx_s = row_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      col_nx_s = col_r + {{(CW-1){1'b0}}, 1'b1};
      row_nx_s = row_r;
    end
  end

  // C is symmetric, so the triangular build drops the strictly-upper words.
  always_comb begin
`ifdef SYRK_LOWER_TRI_EN
    c_keep_s = (col_r <= row_r);
`else
    c_keep_s = 1'b1;
`endif
  end

  // Stream sequencer: scalars, A words, C words, then wait for rearm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_ALPHA;
      col_r     <= {CW{1'b0}};
      row_r     <= {CW{1'b0}};
      addr_r    <= {AW{1'b0}};
      alpha_r   <= {DW{1'b0}};
      beta_r    <= {DW{1'b0}};
      a_we_r    <= 1'b0;
      c_we_r    <= 1'b0;
      wr_addr_r <= {AW{1'b0}};
      wr_data_r <= {DW{1'b0}};
      start_r   <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      a_we_r  <= 1'b0;
      c_we_r  <= 1'b0;
      start_r <= 1'b0;
      case (state_r)
        S_ALPHA: begin
          if (bus.din_valid) begin
            alpha_r <= bus.Din;
            busy_r  <= 1'b1;
            state_r <= S_BETA;
          end
        end
        S_BETA: begin
          if (bus.din_valid) begin
            beta_r  <= bus.Din;
            col_r   <= {CW{1'b0}};
            row_r   <= {CW{1'b0}};
            addr_r  <= {AW{1'b0}};
            state_r <= S_A;
          end
        end
        S_A, S_C: begin
          if (bus.din_valid) begin
            wr_addr_r <= addr_r;
            wr_data_r <= bus.Din;
            if (state_r == S_A) begin
              a_we_r <= 1'b1;
            end else begin
              c_we_r <= c_keep_s;
            end
            if (last_s) begin
              col_r  <= {CW{1'b0}};
              row_r  <= {CW{1'b0}};
              addr_r <= {AW{1'b0}};
              if (state_r == S_A) begin
                state_r <= S_C;
              end else begin
                start_r <= 1'b1;
                busy_r  <= 1'b0;
                state_r <= S_DONE;
              end
            end else begin
              col_r  <= col_nx_s;
              row_r  <= row_nx_s;
              addr_r <= addr_nx_s;
            end
          end
        end
        S_DONE: begin
          // A word arriving here is dropped, even alongside rearm.
          if (bus.din_valid) begin
            overrun_r <= 1'b1;
          end
          if (bus.rearm) begin
            state_r <= S_ALPHA;
          end
        end
        default: begin
          state_r <= S_ALPHA;
        end
      endcase
    end
  end

  assign bus.alpha   = alpha_r;
  assign bus.beta    = beta_r;
  assign bus.a_we    = a_we_r;
  assign bus.c_we    = c_we_r;
  assign bus.wr_addr = wr_addr_r;
  assign bus.wr_data = wr_data_r;
  assign bus.start   = start_r;
  assign bus.busy    = busy_r;
  assign bus.overrun = overrun_r;

endmodule
